// File: rtl/cordic_rr_scheduler_pkg.sv
// Shared types and constants for the CORDIC round-robin scheduler.
package cordic_rr_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int          CORDIC_ITERS = 32;
    localparam logic [31:0] Q_ONE        = 32'h4000_0000;
    localparam logic [31:0] Q_PI_4       = 32'h3243_F6A8;

    // Port position k steps after base, wrapping at n.
    function automatic int rr_pos(input int base, input int k, input int n);
        return (base + k) % n;
    endfunction

endpackage

// File: rtl/cordic_rr_scheduler_if.sv
// Requester-side bus: per-port request/angle in, shared response out.
interface cordic_rr_scheduler_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32
);
    logic [N_REQ-1:0]             req;
    logic [N_REQ-1:0][DATA_W-1:0] req_angle;
    logic [N_REQ-1:0]             resp_valid;
    logic [DATA_W-1:0]            resp_result;
    logic                         resp_err;

    modport master (output req, output req_angle,
                    input  resp_valid, input resp_result, input resp_err);
    modport slave  (input  req, input  req_angle,
                    output resp_valid, output resp_result, output resp_err);
endinterface

// File: rtl/cordic_rr_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request after last_grant.
module cordic_rr_scheduler_rr_arbiter
    import cordic_rr_scheduler_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N_REQ-1:0] grant_oh,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);
    logic [IDX_W-1:0] pos;

    // Scan last_grant+1 .. last_grant+N_REQ; the first hit wins.
    always_comb begin
        any       = 1'b0;
        grant_idx = '0;
        grant_oh  = '0;
        pos       = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            pos = IDX_W'(rr_pos(int'(last_grant), k, N_REQ));
            if (!any && req[pos]) begin
                any       = 1'b1;
                grant_idx = pos;
            end
        end
        if (any) grant_oh[grant_idx] = 1'b1;
    end

endmodule

// File: rtl/cordic_rr_scheduler.sv
// Shares one iterative CORDIC cosine core among N_REQ requesters:
// round-robin grant, one-cycle start, watchdog on done, one-cycle response.
module cordic_rr_scheduler
    import cordic_rr_scheduler_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 40,
    localparam int IDX_W  = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    cordic_rr_scheduler_if.slave  bus,
    output logic                  busy,
    output logic [IDX_W-1:0]      grant_id,
    output logic                  core_clk_en,
    output logic                  core_reset,
    output logic                  core_start,
    output logic [DATA_W-1:0]     core_dataa,
    input  logic [DATA_W-1:0]     core_result,
    input  logic                  core_done
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    state_t            state, state_nx;
    logic [IDX_W-1:0]  last_grant;
    logic [WD_W-1:0]   wdog;
    logic [N_REQ-1:0]  arb_oh;
    logic [IDX_W-1:0]  arb_idx;
    logic              arb_any;
    logic [DATA_W-1:0] angle_sel;
    logic              wd_abort;

    assign core_clk_en = 1'b1;

    cordic_rr_scheduler_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req        (bus.req),
        .last_grant (last_grant),
        .grant_oh   (arb_oh),
        .grant_idx  (arb_idx),
        .any        (arb_any)
    );

    // Next state, watchdog abort and one-hot angle select.
    always_comb begin
        state_nx  = state;
        wd_abort  = (state == BUSY) && !core_done && (wdog == '0);
        angle_sel = '0;
        for (int i = 0; i < N_REQ; i++)
            if (arb_oh[i]) angle_sel = angle_sel | bus.req_angle[i];
        case (state)
            IDLE:    if (arb_any) state_nx = ISSUE;
            ISSUE:   state_nx = BUSY;
            BUSY:    if (core_done || wdog == '0) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;

    // Registered outputs, grant bookkeeping and watchdog; core_done outside BUSY is ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy            <= 1'b0;
            core_start      <= 1'b0;
            core_reset      <= 1'b1;
            core_dataa      <= '0;
            grant_id        <= '0;
            last_grant      <= IDX_W'(N_REQ - 1);
            wdog            <= '0;
            bus.resp_valid  <= '0;
            bus.resp_result <= '0;
            bus.resp_err    <= 1'b0;
        end else begin
            busy           <= (state_nx != IDLE);
            core_start     <= (state == IDLE) && arb_any;
            core_reset     <= wd_abort;
            bus.resp_valid <= '0;
            if (state == IDLE && arb_any) begin
                grant_id   <= arb_idx;
                core_dataa <= angle_sel;
            end
            if (state == ISSUE)
                wdog <= WD_W'(TIMEOUT);
            else if (state == BUSY && wdog != '0)
                wdog <= wdog - 1'b1;
            if (state == BUSY && core_done) begin
                bus.resp_result          <= core_result;
                bus.resp_err             <= 1'b0;
                bus.resp_valid[grant_id] <= 1'b1;
            end else if (wd_abort) begin
                bus.resp_result          <= '0;
                bus.resp_err             <= 1'b1;
                bus.resp_valid[grant_id] <= 1'b1;
            end
            if (state == RESP) last_grant <= grant_id;
        end
    end

endmodule

// File: tb/tb_cordic_rr_scheduler.sv
// Bench for cordic_rr_scheduler with a behavioural cosine core stand-in.
module tb_cordic_rr_scheduler;
    import cordic_rr_scheduler_pkg::*;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int TO = 40;
    localparam int IW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          busy, core_clk_en, core_reset, core_start, core_done;
    logic [IW-1:0] grant_id;
    logic [W-1:0]  core_dataa, core_result;

    cordic_rr_scheduler_if #(.N_REQ(N), .DATA_W(W)) bus ();

    cordic_rr_scheduler #(.N_REQ(N), .DATA_W(W), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .busy        (busy),
        .grant_id    (grant_id),
        .core_clk_en (core_clk_en),
        .core_reset  (core_reset),
        .core_start  (core_start),
        .core_dataa  (core_dataa),
        .core_result (core_result),
        .core_done   (core_done)
    );

    // Core stand-in: done pulses 32 cycles after start, result = cos(angle).
    logic         hang = 1'b0, inj_done = 1'b0, st_active = 1'b0, st_done = 1'b0;
    int           st_cnt = 0;
    logic [W-1:0] st_res = '0;

    function automatic logic [31:0] cos_q(input logic [31:0] a);
        real r;
        r = $cos(real'($signed(a)) / 1073741824.0) * 1073741824.0;
        return 32'($rtoi(r));
    endfunction

    always @(posedge clk) begin
        st_done <= 1'b0;
        if (core_reset) begin
            st_active <= 1'b0;
            st_cnt    <= 0;
        end else if (core_start) begin
            st_active <= 1'b1;
            st_cnt    <= 0;
            st_res    <= cos_q(core_dataa);
        end else if (st_active) begin
            st_cnt <= st_cnt + 1;
            if (st_cnt == CORDIC_ITERS - 2 && !hang) begin
                st_done   <= 1'b1;
                st_active <= 1'b0;
            end
        end
    end
    assign core_done   = st_done | inj_done;
    assign core_result = st_res;

    typedef struct { int port; logic [31:0] res; logic err; } exp_t;
    typedef struct { int port; logic [31:0] angle; logic [31:0] res; } vec_t;

    exp_t sb[$];
    int   rc[$];
    vec_t vt[6];
    int   n_vec = 0, n_err = 0, cyc = 0, resp_cyc = 0, n_resp = 0, n_crst = 0;
    int   t0, r0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // One cycle; responses are scored here and the served req is dropped.
    task automatic tick();
        exp_t e;
        int   d;
        @(negedge clk);
        cyc++;
        if (core_reset) n_crst++;
        if (|bus.resp_valid) begin
            resp_cyc = cyc;
            n_resp++;
            rc.push_back(cyc);
            if (sb.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_resp: got %b want none", bus.resp_valid);
            end else begin
                e = sb.pop_front();
                chk("resp_port", 32'(bus.resp_valid), 32'(1 << e.port));
                chk("resp_err", 32'(bus.resp_err), 32'(e.err));
                d = int'($signed(bus.resp_result)) - int'($signed(e.res));
                n_vec++;
                if (d > 16 || d < -16) begin
                    n_err++;
                    $display("FAIL resp_result: got %h want %h +-16", bus.resp_result, e.res);
                end
            end
            bus.req = bus.req & ~bus.resp_valid;
        end
    endtask

    task automatic wait_drain(input int budget);
        for (int k = 0; k < budget; k++) begin
            tick();
            if (sb.size() == 0 && !busy) return;
        end
        n_vec++; n_err++;
        $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic post(input int p, input logic [31:0] ang, input logic [31:0] res, input logic err);
        exp_t e;
        bus.req_angle[p] = ang;
        bus.req[p]       = 1'b1;
        e.port = p; e.res = res; e.err = err;
        sb.push_back(e);
    endtask

    initial begin
        vt[0] = '{0, 32'h0000_0000, Q_ONE};
        vt[1] = '{1, Q_PI_4,        32'h2D41_3CCD};
        vt[2] = '{2, 32'h4305_48E1, 32'h2000_0000};
        vt[3] = '{3, 32'hBCFA_B71F, 32'h2000_0000};
        vt[4] = '{0, 32'h6487_ED51, 32'h0000_0000};
        vt[5] = '{2, 32'hCDBC_0958, 32'h2D41_3CCD};

        reset_n = 1'b0;
        bus.req = '0;
        bus.req_angle = '0;
        repeat (3) tick();
        chk("rst_busy",        32'(busy), 0);
        chk("rst_resp_valid",  32'(bus.resp_valid), 0);
        chk("rst_resp_result", bus.resp_result, 0);
        chk("rst_resp_err",    32'(bus.resp_err), 0);
        chk("rst_core_start",  32'(core_start), 0);
        chk("rst_core_dataa",  core_dataa, 0);
        chk("rst_grant_id",    32'(grant_id), 0);
        chk("rst_core_reset",  32'(core_reset), 1);
        chk("core_clk_en",     32'(core_clk_en), 1);
        reset_n = 1'b1;
        tick();
        chk("core_reset_release", 32'(core_reset), 0);

        // Single requests: latency, busy window and result.
        foreach (vt[i]) begin
            post(vt[i].port, vt[i].angle, vt[i].res, 1'b0);
            t0 = cyc;
            tick();
            chk("busy_c1",  32'(busy), 1);
            chk("start_c1", 32'(core_start), 1);
            chk("dataa_c1", core_dataa, vt[i].angle);
            wait_drain(100);
            chk("latency", 32'(resp_cyc - t0), 34);
            chk("busy_after", 32'(busy), 0);
        end

        // All four together after reset: 0,1,2,3, 35 cycles apart; then 0 and 2.
        do_reset();
        rc.delete();
        for (int p = 0; p < N; p++) post(p, vt[p].angle, vt[p].res, 1'b0);
        wait_drain(300);
        chk("burst_count", 32'(rc.size()), 4);
        if (rc.size() == 4)
            for (int k = 1; k < 4; k++) chk("burst_spacing", 32'(rc[k] - rc[k-1]), 35);
        post(0, vt[0].angle, vt[0].res, 1'b0);
        post(2, vt[5].angle, vt[5].res, 1'b0);
        wait_drain(200);

        // Core never finishes: watchdog abort, then normal service again.
        hang = 1'b1;
        n_crst = 0;
        post(1, Q_PI_4, 32'h0, 1'b1);
        t0 = cyc;
        wait_drain(150);
        chk("abort_latency", 32'(resp_cyc - t0), TO + 3);
        chk("abort_core_reset_pulses", 32'(n_crst), 1);
        hang = 1'b0;
        post(2, 32'h0, Q_ONE, 1'b0);
        wait_drain(100);

        // Reset mid-BUSY: immediate reset values, then the held req completes.
        do_reset();
        post(3, vt[2].angle, vt[2].res, 1'b0);
        repeat (10) tick();
        chk("midbusy_busy", 32'(busy), 1);
        r0 = n_resp;
        reset_n = 1'b0;
        #1;
        chk("async_busy",       32'(busy), 0);
        chk("async_core_reset", 32'(core_reset), 1);
        chk("async_core_dataa", core_dataa, 0);
        chk("async_resp_valid", 32'(bus.resp_valid), 0);
        repeat (3) tick();
        reset_n = 1'b1;
        wait_drain(100);
        chk("reissue_resp_count", 32'(n_resp - r0), 1);

        // req dropped during BUSY still answers; spurious done in IDLE is ignored.
        post(0, Q_PI_4, 32'h2D41_3CCD, 1'b0);
        repeat (10) tick();
        bus.req[0] = 1'b0;
        r0 = n_resp;
        wait_drain(100);
        chk("dropped_resp_count", 32'(n_resp - r0), 1);
        inj_done = 1'b1;
        tick();
        inj_done = 1'b0;
        repeat (3) tick();
        chk("spurious_busy",     32'(busy), 0);
        chk("spurious_start",    32'(core_start), 0);
        chk("spurious_grant",    32'(grant_id), 0);
        chk("spurious_no_resp",  32'(n_resp - r0), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d want completion", cyc);
        $fatal(1);
    end

endmodule
